afu_write_ctrl: RTL
===================

AFU_WRITE_CTRL -- requirements
Module: afu_write_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte-address width of wr_addr and base_addr.
REQ-002 Parameter LINE_BYTES, default 64: byte stride between consecutive lines; fixed to the 512-bit line size.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that launches a job; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_WIDTH  byte address of line 0; captured on the accepted start.
REQ-007 num_lines  input  16  line count for the job; captured on the accepted start.
REQ-008 output_fifo_dout  input  512  head word of the upstream first-word-fall-through FIFO; valid whenever output_fifo_empty=0.
REQ-009 output_fifo_empty  input  1  upstream FIFO empty flag.
REQ-010 output_fifo_re  output  1  pop strobe; the head word is consumed on the same edge.
REQ-011 wr_valid  output  1  write request valid.
REQ-012 wr_addr  output  ADDR_WIDTH  write byte address.
REQ-013 wr_data  output  512  write line data.
REQ-014 wr_ready  input  1  downstream accepts the request when wr_valid=1 and wr_ready=1 on the same edge.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle pulse at job completion.
REQ-017 lines_written  output  16  count of accepted requests in the current or last job.

Function
REQ-018 States: IDLE, RUN and DONE; IDLE->RUN on start=1, registering base_addr and num_lines, clearing the pop and accept counters and clearing lines_written.
REQ-019 start=1 with num_lines=0: IDLE->DONE, with no pop and no request.
REQ-020 Output register holds one entry (wr_valid, wr_addr, wr_data); "free" means wr_valid=0, or wr_valid=1 and wr_ready=1 in the current cycle.
REQ-021 output_fifo_re is combinational: it equals (state==RUN) and not output_fifo_empty and register free and pop_count<num_lines.
REQ-022 On output_fifo_re=1, the following edge loads wr_data<=output_fifo_dout, loads wr_addr<=base_addr+pop_count*LINE_BYTES (modulo 2^ADDR_WIDTH), sets wr_valid<=1 and increments pop_count.
REQ-023 Latency: a word at the FIFO head with empty=0 and the register free appears on wr_valid/wr_data on the next edge.
REQ-024 Throughput: one line per cycle when the FIFO is never empty and wr_ready is held high.
REQ-025 While wr_valid=1 and wr_ready=0, wr_addr and wr_data remain stable and no pop occurs.
REQ-026 An accept with no simultaneous pop clears wr_valid; an accept with a simultaneous pop keeps wr_valid=1 and loads the new entry.
REQ-027 Each accept increments lines_written; the counter saturates at num_lines by construction.
REQ-028 RUN->DONE on the edge where the accept makes lines_written equal num_lines; done=1 for exactly the DONE cycle, followed unconditionally by DONE->IDLE.
REQ-029 The block never pops more than num_lines words; excess FIFO contents remain in the FIFO.
REQ-030 start is ignored in RUN and DONE.
REQ-031 An empty FIFO in RUN stalls the block indefinitely with no timeout.

Reset
REQ-032 On reset=0, asynchronously: state=IDLE; and wr_valid, output_fifo_re, busy, done=0; and wr_addr, wr_data, lines_written and the internal counters =0.
REQ-033 Reset asserted mid-job abandons the job; the lines already popped are lost, and the block accepts a new start after reset deasserts.

Verification
REQ-034 base_addr=0x1000, num_lines=4, FIFO pre-loaded with D0..D3, wr_ready=1 -> wr_addr 0x1000, 0x1040, 0x1080 and 0x10C0 on 4 consecutive cycles, starting 1 cycle after the first re; done pulses once; lines_written=4.
REQ-035 Same job with wr_ready low for 3 cycles while the first request is pending -> wr_data=D0 and wr_addr=0x1000 held stable, no re during the stall, all 4 lines delivered in order.
REQ-036 num_lines=2 with the FIFO holding 5 words -> exactly 2 re pulses; 3 words remain; done pulses once.
REQ-037 num_lines=0 -> done pulses 1 cycle after start; re never asserts; wr_valid never asserts.
REQ-038 base_addr=0xFFFFFFC0, num_lines=2 -> wr_addr 0xFFFFFFC0, then 0x00000000 (wrap).
REQ-039 reset driven low after 2 of 6 accepts, then a new start with num_lines=1 -> outputs read 0 during reset; the new job completes with lines_written=1, a single done pulse, and start ignored while busy.

Source files
------------

// File: rtl/afu_write_ctrl.sv
// AFU write controller: drains a first-word-fall-through FIFO of 512-bit lines
// into a single-entry write request register, addressing consecutive lines.
module afu_write_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_lines,
  input  logic [511:0]          output_fifo_dout,
  input  logic                  output_fifo_empty,
  output logic                  output_fifo_re,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [511:0]          wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           lines_written
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(LINE_BYTES);

  state_e                state_q, state_d;
  logic [15:0]           num_q, num_d;
  logic [15:0]           pop_cnt_q, pop_cnt_d;
  logic [15:0]           lines_q, lines_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [511:0]          wr_data_q, wr_data_d;

  logic reg_free;
  logic accept;
  logic pop;

  // The output register can take a new line when empty or draining this cycle.
  assign reg_free = !wr_valid_q || wr_ready;
  assign accept   = wr_valid_q && wr_ready;
  assign pop      = (state_q == RUN) && !output_fifo_empty && reg_free &&
                    (pop_cnt_q < num_q);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves a latch.
    state_d     = state_q;
    num_d       = num_q;
    pop_cnt_d   = pop_cnt_q;
    lines_d     = lines_q;
    next_addr_d = next_addr_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d       = num_lines;
          next_addr_d = base_addr;
          pop_cnt_d   = '0;
          lines_d     = '0;
          state_d     = (num_lines == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          wr_valid_d = 1'b0;
          lines_d    = lines_q + 16'd1;
          if (lines_q + 16'd1 == num_q) state_d = DONE;
        end
        // A pop in the same cycle as an accept refills the register.
        if (pop) begin
          wr_valid_d  = 1'b1;
          wr_addr_d   = next_addr_q;
          wr_data_d   = output_fifo_dout;
          next_addr_d = next_addr_q + STRIDE;
          pop_cnt_d   = pop_cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      num_q       <= '0;
      pop_cnt_q   <= '0;
      lines_q     <= '0;
      next_addr_q <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      // NOTE: the wide data register is reset too, so a reset shows all-zero
      // outputs rather than the last line of an abandoned job.
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      pop_cnt_q   <= pop_cnt_d;
      lines_q     <= lines_d;
      next_addr_q <= next_addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign output_fifo_re = pop;
  assign wr_valid       = wr_valid_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign lines_written  = lines_q;

endmodule
